rom_mapper_detect: RTL and testbench
====================================

# rom_mapper_detect

Watches the HPS ROM download stream (ioctl) for a cartridge slot and measures the image size. It heuristically classifies the megaROM mapper by counting `LD (nn),A` writes to known bank-switch addresses. When the download ends it presents `rom_size`, `rom_mapper` and `loaded`, which the cartridge configuration stage consumes as its ROM-load descriptor. It sits between the ioctl download port and the slot/mapper configuration logic.

## Interface
Parameters:
- ROM_INDEX, 6'd1: ioctl_index value that selects this detector; downloads with any other index are ignored.

Ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- ioctl_download  in  1  high while an HPS download is in progress.
- ioctl_index  in  6  download target index.
- ioctl_wr  in  1  one-cycle strobe; `ioctl_addr`/`ioctl_dout` are valid.
- ioctl_addr  in  25  byte address within the image.
- ioctl_dout  in  8  data byte.
- rom_size  out  25  highest written address + 1.
- rom_mapper  out  6  mapper_typ_t code: 0 NO_UNKNOWN, 1 ASCII8, 2 ASCII16, 3 KONAMI, 4 KONAMI_SCC, 6 LINEAR.
- loaded  out  1  result valid for the most recent download.
- busy  out  1  download in progress or decision pending.

## Operation
- `active` = ioctl_download & (ioctl_index == ROM_INDEX). A byte is accepted only when `ioctl_wr` is high and `active` is high.
- Top FSM:
  - IDLE → RUN on the rising edge of `active`. On entry, clear the size register, all vote counters and `loaded`.
  - RUN → DECIDE when `active` is first sampled low.
  - DECIDE → IDLE after exactly one cycle. In that cycle `rom_size`, `rom_mapper` and `loaded` are written.
- Size register: on each accepted byte, if ioctl_addr + 1 is greater than the stored size, store ioctl_addr + 1. Width is 25 bits with no wrap; the maximum is 0x1FFFFFF + 1, which truncates to 0 and is accepted as out of range.
- Pattern matcher (runs only in RUN; advances only on accepted bytes):
  - S0: a byte of 0x32 → S1; any other byte stays in S0.
  - S1: the byte is latched as the low address byte → S2.
  - S2: the byte is the high address byte. Form addr = {hi, lo}, apply votes, → S0.
  - No resynchronisation inside S1 or S2: 0x32 bytes there are consumed as address bytes.
- Votes (each counter is 8 bits and saturates at 255). An address outside this list casts no vote:
  - 0x4000, 0x8000, 0xA000 → KONAMI.
  - 0x5000, 0x9000, 0xB000 → KONAMI_SCC.
  - 0x6000 → KONAMI, ASCII8, ASCII16.
  - 0x7000 → KONAMI_SCC, ASCII8, ASCII16.
  - 0x6800, 0x7800 → ASCII8.
  - 0x77FF → ASCII16.
- Decision (combinational from the counters and size, registered in DECIDE):
  - size == 0 → mapper NO_UNKNOWN and `loaded` = 0.
  - All counters 0 → LINEAR if size ≤ 0x10000, otherwise NO_UNKNOWN. `loaded` = 1.
  - Otherwise the counter with the largest value wins. Ties are broken by priority KONAMI_SCC > KONAMI > ASCII16 > ASCII8. `loaded` = 1.
- The matcher state resets to S0 when entering RUN. A pattern left incomplete when the download ends is discarded.
- A new download on a different index neither changes outputs nor clears `loaded`.

## Timing
- Reset values: `rom_size` = 0, `rom_mapper` = 0 (NO_UNKNOWN), `loaded` = 0, `busy` = 0, FSM = IDLE, matcher = S0, counters = 0.
- Asserting reset_n low mid-download aborts immediately; all state returns to reset values.
  - If `active` is still high after reset_n releases, the next sampled rising edge of `active` is required to start a run. A download already in progress at release is ignored until it drops.
- Vote counters update on the clock edge that accepts the high byte.
- Size updates on the edge that accepts the byte.
- `busy` is high in RUN and DECIDE, and goes high the cycle after `active` rises.
- Latency: if `active` is low at edge N, outputs are updated and `busy` = 0 after edge N+2. `loaded` and `rom_mapper` change together on the same edge.
- `loaded` falls the cycle after `active` rises for a new matching download.
- `ioctl_wr` coinciding with `active` falling is not accepted (qualified by `active`).

## Test plan
- 32 KB image of 0x00 bytes, index = ROM_INDEX → rom_size = 0x08000, rom_mapper = 6 (LINEAR), loaded = 1, two cycles after download drops.
- 128 KB image with three `32 00 50` sequences and one `32 00 60` → votes SCC 3, KONAMI 1, ASCII8 1, ASCII16 1 → rom_mapper = 4.
- 128 KB image with a single `32 00 60` → three-way tie → rom_mapper = 3 (KONAMI). Image with 300× `32 FF 77` → ASCII16 counter = 255 (saturated), rom_mapper = 2.
- Byte stream `32 00 32 00 50` in a 128 KB image → forms address 0x3200, no votes → rom_mapper = 0 (NO_UNKNOWN), loaded = 1.
- Download with ioctl_index ≠ ROM_INDEX after a valid load → outputs and loaded = 1 are unchanged. Zero-byte matching download → loaded = 0, mapper 0.
- reset_n pulsed low halfway through a 64 KB download → all outputs 0 asynchronously. No result is produced for the rest of that download. A subsequent full download classifies correctly.

Source files
------------

// File: rtl/rom_mapper_detect.sv
// rom_mapper_detect
// Watches the HPS ioctl download stream for one cartridge slot, tracks the
// image size and guesses the megaROM mapper by counting "LD (nn),A" (opcode
// 0x32) writes to well-known bank-switch addresses. The result is published
// two cycles after the download ends.
//
// Ports
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   ioctl_download high while an HPS download is in progress
//   ioctl_index    download target index, compared against ROM_INDEX
//   ioctl_wr       one-cycle byte strobe
//   ioctl_addr     byte address within the image
//   ioctl_dout     data byte
//   rom_size       highest written address + 1
//   rom_mapper     mapper code (0 none, 1 ASCII8, 2 ASCII16, 3 KONAMI,
//                  4 KONAMI_SCC, 6 LINEAR)
//   loaded         result valid for the most recent matching download
//   busy           download running or decision pending
module rom_mapper_detect #(
  parameter logic [5:0] ROM_INDEX = 6'd1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [5:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [24:0] rom_size,
  output logic [5:0]  rom_mapper,
  output logic        loaded,
  output logic        busy
);

  localparam logic [5:0] MAP_NONE    = 6'd0;
  localparam logic [5:0] MAP_ASCII8  = 6'd1;
  localparam logic [5:0] MAP_ASCII16 = 6'd2;
  localparam logic [5:0] MAP_KONAMI  = 6'd3;
  localparam logic [5:0] MAP_SCC     = 6'd4;
  localparam logic [5:0] MAP_LINEAR  = 6'd6;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DECIDE} top_state_t;
  typedef enum logic [1:0] {M_S0, M_S1, M_S2} match_state_t;

  top_state_t   state_q;
  match_state_t match_q;
  logic         active_q;
  logic [24:0]  size_q;
  logic [7:0]   lo_q;
  logic [7:0]   cnt_k_q, cnt_scc_q, cnt_a8_q, cnt_a16_q;
  logic [24:0]  rom_size_q;
  logic [5:0]   rom_mapper_q;
  logic         loaded_q;

  logic         active;
  logic         accept;
  logic [24:0]  size_inc;
  logic [15:0]  pat_addr;
  logic         vote_k, vote_scc, vote_a8, vote_a16;
  logic [7:0]   best_cnt;
  logic [5:0]   mapper_d;
  logic         loaded_d;

  assign active   = ioctl_download && (ioctl_index == ROM_INDEX);
  assign accept   = ioctl_wr && active && (state_q == ST_RUN);
  // Truncates to 0 at the very top address, which then never grows the size.
  assign size_inc = ioctl_addr + 25'd1;
  assign pat_addr = {ioctl_dout, lo_q};

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic en);
    return (en && (v != 8'hFF)) ? v + 8'd1 : v;
  endfunction

  // Which mappers a completed "LD (pat_addr),A" votes for.
  always_comb begin
    vote_k   = 1'b0;
    vote_scc = 1'b0;
    vote_a8  = 1'b0;
    vote_a16 = 1'b0;
    case (pat_addr)
      16'h4000, 16'h8000, 16'hA000: vote_k = 1'b1;
      16'h5000, 16'h9000, 16'hB000: vote_scc = 1'b1;
      16'h6000: begin vote_k = 1'b1; vote_a8 = 1'b1; vote_a16 = 1'b1; end
      16'h7000: begin vote_scc = 1'b1; vote_a8 = 1'b1; vote_a16 = 1'b1; end
      16'h6800, 16'h7800: vote_a8 = 1'b1;
      16'h77FF: vote_a16 = 1'b1;
      default: ;
    endcase
  end

  // Strict ">" keeps the earlier (higher priority) candidate on ties.
  always_comb begin
    best_cnt = cnt_scc_q;
    mapper_d = MAP_SCC;
    loaded_d = 1'b1;
    if (cnt_k_q > best_cnt) begin
      best_cnt = cnt_k_q;
      mapper_d = MAP_KONAMI;
    end
    if (cnt_a16_q > best_cnt) begin
      best_cnt = cnt_a16_q;
      mapper_d = MAP_ASCII16;
    end
    if (cnt_a8_q > best_cnt) begin
      best_cnt = cnt_a8_q;
      mapper_d = MAP_ASCII8;
    end
    if (size_q == 25'd0) begin
      mapper_d = MAP_NONE;
      loaded_d = 1'b0;
    end else if ((cnt_k_q | cnt_scc_q | cnt_a8_q | cnt_a16_q) == 8'd0) begin
      mapper_d = (size_q <= 25'h10000) ? MAP_LINEAR : MAP_NONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      match_q      <= M_S0;
      // Starts high so a download already running at reset release is not
      // mistaken for a fresh rising edge.
      active_q     <= 1'b1;
      size_q       <= '0;
      lo_q         <= '0;
      cnt_k_q      <= '0;
      cnt_scc_q    <= '0;
      cnt_a8_q     <= '0;
      cnt_a16_q    <= '0;
      rom_size_q   <= '0;
      rom_mapper_q <= MAP_NONE;
      loaded_q     <= 1'b0;
    end else begin
      active_q <= active;
      case (state_q)
        ST_IDLE: begin
          if (active && !active_q) begin
            state_q   <= ST_RUN;
            match_q   <= M_S0;
            size_q    <= '0;
            cnt_k_q   <= '0;
            cnt_scc_q <= '0;
            cnt_a8_q  <= '0;
            cnt_a16_q <= '0;
            loaded_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          // Leaving on the registered copy adds the cycle that makes the
          // result appear two edges after the download drops.
          if (!active_q) begin
            state_q <= ST_DECIDE;
          end else if (accept) begin
            if (size_inc > size_q) size_q <= size_inc;
            case (match_q)
              M_S0: if (ioctl_dout == 8'h32) match_q <= M_S1;
              M_S1: begin
                lo_q    <= ioctl_dout;
                match_q <= M_S2;
              end
              default: begin
                cnt_k_q   <= sat_inc(cnt_k_q, vote_k);
                cnt_scc_q <= sat_inc(cnt_scc_q, vote_scc);
                cnt_a8_q  <= sat_inc(cnt_a8_q, vote_a8);
                cnt_a16_q <= sat_inc(cnt_a16_q, vote_a16);
                match_q   <= M_S0;
              end
            endcase
          end
        end
        default: begin
          rom_size_q   <= size_q;
          rom_mapper_q <= mapper_d;
          loaded_q     <= loaded_d;
          match_q      <= M_S0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign rom_size   = rom_size_q;
  assign rom_mapper = rom_mapper_q;
  assign loaded     = loaded_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rom_mapper_detect.sv
// Self-checking bench for rom_mapper_detect: directed cases plus randomized
// byte streams, each compared against a behavioural model of the rules.
module tb_rom_mapper_detect;

  localparam logic [5:0] IDX = 6'd1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [5:0]  ioctl_index = 6'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [24:0] rom_size;
  logic [5:0]  rom_mapper;
  logic        loaded;
  logic        busy;

  rom_mapper_detect #(.ROM_INDEX(IDX)) dut (
    .clk(clk), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .rom_size(rom_size), .rom_mapper(rom_mapper),
    .loaded(loaded), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [24:0] a_q[$];
  logic [7:0]  d_q[$];
  int unsigned next_a;

  logic [24:0] exp_size;
  logic [5:0]  exp_map;
  logic        exp_ld;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    a_q.delete();
    d_q.delete();
    next_a = 0;
  endtask

  task automatic push_b(input logic [7:0] d);
    a_q.push_back(25'(next_a));
    d_q.push_back(d);
    next_a++;
  endtask

  task automatic push_at(input logic [24:0] a, input logic [7:0] d);
    a_q.push_back(a);
    d_q.push_back(d);
  endtask

  task automatic push_pat(input logic [15:0] addr);
    push_b(8'h32);
    push_b(addr[7:0]);
    push_b(addr[15:8]);
  endtask

  // Vote mask for a target address: bit0 SCC, bit1 KONAMI, bit2 ASCII16, bit3 ASCII8
  function automatic logic [3:0] votes_for(input int unsigned a);
    case (a)
      32'h4000, 32'h8000, 32'hA000: return 4'b0010;
      32'h5000, 32'h9000, 32'hB000: return 4'b0001;
      32'h6000: return 4'b1110;
      32'h7000: return 4'b1101;
      32'h6800, 32'h7800: return 4'b1000;
      32'h77FF: return 4'b0100;
      default: return 4'b0000;
    endcase
  endfunction

  // Reference: scan the byte list for 3-byte patterns, tally saturating
  // votes, then pick by count with SCC > KONAMI > ASCII16 > ASCII8 on ties.
  task automatic model();
    int v[4];
    int unsigned s;
    int unsigned t;
    int i;
    int best;
    logic [3:0] mask;
    s = 0;
    for (int j = 0; j < 4; j++) v[j] = 0;
    foreach (a_q[k]) begin
      t = (int'(a_q[k]) + 1) % 33554432;
      if (t > s) s = t;
    end
    i = 0;
    while (i < d_q.size()) begin
      if (d_q[i] == 8'h32) begin
        if (i + 2 >= d_q.size()) break;
        mask = votes_for({16'd0, d_q[i+2], d_q[i+1]});
        for (int j = 0; j < 4; j++)
          if (mask[j] && v[j] < 255) v[j]++;
        i += 3;
      end else begin
        i++;
      end
    end
    exp_size = 25'(s);
    if (s == 0) begin
      exp_map = 6'd0;
      exp_ld  = 1'b0;
    end else if (v[0] + v[1] + v[2] + v[3] == 0) begin
      exp_map = (s <= 65536) ? 6'd6 : 6'd0;
      exp_ld  = 1'b1;
    end else begin
      best = 0;
      for (int j = 1; j < 4; j++)
        if (v[j] > v[best]) best = j;
      case (best)
        0: exp_map = 6'd4;
        1: exp_map = 6'd3;
        2: exp_map = 6'd2;
        default: exp_map = 6'd1;
      endcase
      exp_ld = 1'b1;
    end
  endtask

  task automatic send_bytes(input int from, input int upto);
    for (int k = from; k < upto; k++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = a_q[k];
      ioctl_dout = d_q[k];
      @(negedge clk);
      ioctl_wr = 1'b0;
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
  endtask

  task automatic check_out(input string tag);
    chk({tag, ".size"}, 32'(rom_size), 32'(exp_size));
    chk({tag, ".mapper"}, 32'(rom_mapper), 32'(exp_map));
    chk({tag, ".loaded"}, 32'(loaded), 32'(exp_ld));
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    $display("[TB] %s: size=0x%0h mapper=%0d loaded=%0d", tag, rom_size, rom_mapper, loaded);
  endtask

  // Full download of the queued stream; stray_wr pulses a write on the
  // cycle the download drops, which must be ignored.
  task automatic run_dl(input string tag, input logic [5:0] idx, input bit stray_wr);
    bit match;
    match = (idx == IDX);
    @(negedge clk);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    @(negedge clk);
    if (match) begin
      chk({tag, ".busy_start"}, 32'(busy), 32'd1);
      chk({tag, ".loaded_clr"}, 32'(loaded), 32'd0);
    end
    send_bytes(0, a_q.size());
    ioctl_download = 1'b0;
    if (stray_wr) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'h1FFFF0;
      ioctl_dout = 8'h32;
    end
    @(negedge clk);
    ioctl_wr = 1'b0;
    @(negedge clk);
    if (match) chk({tag, ".busy_decide"}, 32'(busy), 32'd1);
    @(negedge clk);
    if (match) model();
    check_out(tag);
  endtask

  initial begin
    exp_size = '0; exp_map = '0; exp_ld = 1'b0;
    repeat (3) @(negedge clk);
    check_out("reset");
    reset_n = 1'b1;
    @(negedge clk);

    clr(); for (int k = 0; k < 8; k++) push_b(8'h00); push_at(25'h7FFF, 8'h00);
    run_dl("linear32k", IDX, 1'b0);
    chk("linear32k.code", 32'(rom_mapper), 32'd6);

    clr(); repeat (3) push_pat(16'h5000); push_pat(16'h6000); push_at(25'h1FFFF, 8'h00);
    run_dl("scc", IDX, 1'b1);
    chk("scc.code", 32'(rom_mapper), 32'd4);

    clr(); push_pat(16'h6000); push_at(25'h1FFFF, 8'h00);
    run_dl("tie3", IDX, 1'b0);
    chk("tie3.code", 32'(rom_mapper), 32'd3);

    clr(); repeat (300) push_pat(16'h77FF);
    run_dl("a16sat", IDX, 1'b0);
    chk("a16sat.code", 32'(rom_mapper), 32'd2);

    clr(); repeat (300) push_pat(16'h77FF); repeat (260) push_pat(16'h4000);
    run_dl("bothsat", IDX, 1'b0);

    clr(); push_b(8'h32); push_b(8'h00); push_b(8'h32); push_b(8'h00); push_b(8'h50);
    push_at(25'h1FFFF, 8'h00);
    run_dl("noresync", IDX, 1'b0);
    chk("noresync.code", 32'(rom_mapper), 32'd0);

    clr(); push_b(8'h11); push_at(25'hFFFF, 8'h22);
    run_dl("lin64k", IDX, 1'b0);
    clr(); push_b(8'h11); push_at(25'h10000, 8'h22);
    run_dl("over64k", IDX, 1'b0);

    clr(); for (int k = 0; k < 4; k++) push_b(8'h01); push_at(25'h1FFFFFF, 8'h00);
    run_dl("topaddr", IDX, 1'b0);

    // Foreign index: stream would change everything if it were accepted.
    clr(); push_pat(16'h5000); push_at(25'h3FFFF, 8'h00);
    run_dl("otheridx", 6'd2, 1'b0);

    clr();
    run_dl("empty", IDX, 1'b0);

    clr(); push_pat(16'h4000); push_at(25'h100, 8'h00);
    run_dl("preload", IDX, 1'b0);

    // Reset in the middle of a 64 KB download.
    clr(); for (int k = 0; k < 10; k++) push_pat(16'h9000); push_at(25'hFFFF, 8'h00);
    @(negedge clk);
    ioctl_index = IDX;
    ioctl_download = 1'b1;
    @(negedge clk);
    send_bytes(0, 15);
    #2 reset_n = 1'b0;
    #1;
    exp_size = '0; exp_map = '0; exp_ld = 1'b0;
    check_out("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
    send_bytes(15, a_q.size());
    ioctl_download = 1'b0;
    repeat (3) @(negedge clk);
    check_out("after_rst");
    run_dl("full_after_rst", IDX, 1'b0);

    for (int it = 0; it < 12; it++) begin
      bit no_votes;
      int n;
      logic [15:0] tgt;
      clr();
      no_votes = ($urandom_range(0, 3) == 0);
      n = $urandom_range(5, 40);
      for (int k = 0; k < n; k++) begin
        if (!no_votes && $urandom_range(0, 1) == 0) begin
          case ($urandom_range(0, 13))
            0: tgt = 16'h4000; 1: tgt = 16'h8000; 2: tgt = 16'hA000;
            3: tgt = 16'h5000; 4: tgt = 16'h9000; 5: tgt = 16'hB000;
            6: tgt = 16'h6000; 7: tgt = 16'h7000; 8: tgt = 16'h6800;
            9: tgt = 16'h7800; 10: tgt = 16'h77FF;
            default: tgt = 16'($urandom);
          endcase
          push_pat(tgt);
        end else if (no_votes) begin
          push_b(8'($urandom_range(0, 8'h31)));
        end else begin
          push_b(8'($urandom));
        end
      end
      if ($urandom_range(0, 1) == 0) push_at(25'($urandom_range(0, 32'h3FFFF)), 8'h00);
      run_dl($sformatf("rand%0d", it), IDX, ($urandom_range(0, 1) == 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
